mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_lsu_if.sv | 38 +++
 rtl/mem_stage_lsu.sv | 157 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
// Bundle of request/response and data-memory signals around the MEM-stage LSU.
// slave: the LSU side; master: the pipeline plus data memory driving it.
interface mem_stage_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_we;
  logic        exc_misalign;

  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  mem_rdata,
    output req_ready, resp_valid, resp_data, resp_rd, resp_we, exc_misalign,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_rd, resp_we, exc_misalign,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit on a big-endian word memory; sub-word stores are read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of forcing alignment.
module mem_stage_lsu (
  input  logic clk,
  input  logic rst,
  mem_stage_lsu_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_we;
  logic        r_unsigned;
  logic        r_trap;
  logic        r_rsvd;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [4:0]  r_rd;

  logic        w_accept;
  logic        w_rsvd;
  logic        w_trap;
  logic [31:0] w_addr_fix;
  logic [7:0]  w_lanes [4];
  logic [31:0] w_sb_word;
  logic [31:0] w_sh_word;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;
  logic [31:0] w_load_data;
  logic        w_in_resp;
  logic        w_ok_load;

  assign w_accept = bus.req_valid && (r_state == IDLE);
  assign w_rsvd   = (bus.req_size == 2'b11);

  always_comb begin
    w_addr_fix = bus.req_addr;
    case (bus.req_size)
      2'b01:   w_addr_fix[0]   = 1'b0;
      2'b10:   w_addr_fix[1:0] = 2'b00;
      default: w_addr_fix      = bus.req_addr;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
  assign w_trap = w_misalign;
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_rsvd || w_trap)            w_state_next = RESP;
          else if (!bus.req_we)            w_state_next = RD;
          else if (bus.req_size == 2'b10)  w_state_next = WR;
          else                             w_state_next = RD;
        end
      end
      RD:      w_state_next = r_we ? WR : RESP;
      WR:      w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_trap     <= 1'b0;
      r_rsvd     <= 1'b0;
      r_size     <= 2'b00;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_word     <= 32'd0;
      r_rd       <= 5'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_we       <= bus.req_we;
        r_unsigned <= bus.req_unsigned;
        r_trap     <= w_trap && !w_rsvd;
        r_rsvd     <= w_rsvd;
        r_size     <= bus.req_size;
        r_addr     <= w_addr_fix;
        r_wdata    <= bus.req_wdata;
        r_rd       <= bus.req_rd;
      end
      if (r_state == RD) r_word <= bus.mem_rdata;
    end
  end

  // Byte offset k lives in bits [31-8k -: 8]; a half at offset 0/2 spans two such lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lanes[gi] = r_word[31-8*gi -: 8];
      assign w_sb_word[31-8*gi -: 8] = (r_addr[1:0] == 2'(gi)) ? r_wdata[7:0] : w_lanes[gi];
      assign w_sh_word[31-8*gi -: 8] = (r_addr[1] == 1'(gi / 2)) ? r_wdata[15-8*(gi%2) -: 8]
                                                                  : w_lanes[gi];
    end
  endgenerate

  assign w_ld_byte = w_lanes[r_addr[1:0]];
  assign w_ld_half = r_addr[1] ? {w_lanes[2], w_lanes[3]} : {w_lanes[0], w_lanes[1]};

  always_comb begin
    w_load_data = 32'd0;
    case (r_size)
      2'b00:   w_load_data = {{24{!r_unsigned && w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_load_data = {{16{!r_unsigned && w_ld_half[15]}}, w_ld_half};
      2'b10:   w_load_data = r_word;
      default: w_load_data = 32'd0;
    endcase
  end

  assign w_in_resp = (r_state == RESP);
  assign w_ok_load = !r_we && !r_rsvd && !r_trap;

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = w_in_resp;
  assign bus.resp_we    = w_in_resp && w_ok_load;
  assign bus.resp_data  = (w_in_resp && w_ok_load) ? w_load_data : 32'd0;
  assign bus.resp_rd    = r_rd;
`ifdef LSU_MISALIGN_TRAP_EN
  assign bus.exc_misalign = w_in_resp && r_trap;
`else
  assign bus.exc_misalign = 1'b0;
`endif

  // Gating by rst lets a reset landing on the WR cycle cancel the write.
  assign bus.mem_read  = !rst && (r_state == RD);
  assign bus.mem_write = !rst && (r_state == WR);
  assign bus.mem_addr  = ((r_state == RD) || (r_state == WR)) ? {r_addr[31:2], 2'b00} : 32'd0;

  always_comb begin
    bus.mem_wdata = 32'd0;
    if (r_state == WR) begin
      case (r_size)
        2'b00:   bus.mem_wdata = w_sb_word;
        2'b01:   bus.mem_wdata = w_sh_word;
        default: bus.mem_wdata = r_wdata;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mem_stage_lsu;

  logic clk = 1'b0;
  logic rst;
  logic preload;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        we;
    logic [4:0]  rd;
    logic        exc;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  mem_stage_lsu_if bus();

  mem_stage_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Big-endian word memory, combinational read
  logic [31:0] mem [16];
  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[5:2]] : 32'hDEAD_DEAD;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[1] <= 32'h0102_0304;
      mem[2] <= 32'h1122_80FF;
      mem[3] <= 32'hCAFE_F00D;
    end else if (bus.mem_write) begin
      mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per resp_valid pulse
  always @(negedge clk) begin
    if (!rst) chk("rw_exclusive", 32'(bus.mem_read && bus.mem_write), 32'd0);
    if (bus.resp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rd=%0d data=%h expected no response", bus.resp_rd, bus.resp_data);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("resp_data", bus.resp_data, mon_e.data);
        chk("resp_we", 32'(bus.resp_we), 32'(mon_e.we));
        chk("resp_rd", 32'(bus.resp_rd), 32'(mon_e.rd));
        chk("exc_misalign", 32'(bus.exc_misalign), 32'(mon_e.exc));
        $display("resp rd=%0d data=%h we=%0d exc=%0d cycle=%0d", bus.resp_rd, bus.resp_data,
                 bus.resp_we, bus.exc_misalign, cyc);
      end
    end
  end

  // Presents one request, returns #1 after its accept edge with the bus scrambled.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic expect_resp, input logic [31:0] edata, input logic ewe,
                       input logic eexc, input int lat);
    int n;
    exp_t e;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
    end
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1;
    if (expect_resp) begin
      e.data = edata;
      e.we   = ewe;
      e.rd   = rd;
      e.exc  = eexc;
      e.cyc  = cyc + lat - 1;
      sb_q.push_back(e);
    end
    $display("req we=%0d size=%0d uns=%0d addr=%h wdata=%h rd=%0d accepted at %0d",
             we, size, uns, addr, wdata, rd, cyc);
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_size     = ~size;
    bus.req_unsigned = ~uns;
    bus.req_addr     = 32'hFFFF_FFFF;
    bus.req_wdata    = ~wdata;
    bus.req_rd       = ~rd;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got %0d pending expected 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'd0;
    bus.req_wdata    = 32'd0;
    bus.req_rd       = 5'd0;
    rst     = 1'b1;
    preload = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    preload = 1'b0;
    rst     = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_we", 32'(bus.resp_we), 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("rst_exc", 32'(bus.exc_misalign), 32'd0);
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

    // Loads from word 0x8 = 1122_80FF
    issue(0, 2'b00, 0, 32'hA, 0, 5'd1, 1, 32'hFFFF_FF80, 1, 0, 2); drain();
    issue(0, 2'b00, 1, 32'hA, 0, 5'd2, 1, 32'h0000_0080, 1, 0, 2); drain();
    issue(0, 2'b01, 1, 32'hA, 0, 5'd3, 1, 32'h0000_80FF, 1, 0, 2); drain();
    issue(0, 2'b01, 0, 32'h8, 0, 5'd4, 1, 32'h0000_1122, 1, 0, 2); drain();
    issue(0, 2'b10, 0, 32'h8, 0, 5'd5, 1, 32'h1122_80FF, 1, 0, 2); drain();

    // SB: RD then WR with merged word
    issue(1, 2'b00, 0, 32'h9, 32'h0000_00AB, 5'd6, 1, 32'd0, 0, 0, 3);
    @(negedge clk);
    chk("sb_rd_mem_read", 32'(bus.mem_read), 32'd1);
    chk("sb_rd_mem_addr", bus.mem_addr, 32'h8);
    @(negedge clk);
    chk("sb_wr_mem_write", 32'(bus.mem_write), 32'd1);
    chk("sb_wr_mem_read", 32'(bus.mem_read), 32'd0);
    chk("sb_wr_mem_wdata", bus.mem_wdata, 32'h11AB_80FF);
    drain();
    issue(0, 2'b10, 0, 32'h8, 0, 5'd5, 1, 32'h11AB_80FF, 1, 0, 2); drain();

    // SW goes straight to WR
    issue(1, 2'b10, 0, 32'h4, 32'hDEAD_BEEF, 5'd7, 1, 32'd0, 0, 0, 2);
    @(negedge clk);
    chk("sw_mem_write", 32'(bus.mem_write), 32'd1);
    chk("sw_mem_read", 32'(bus.mem_read), 32'd0);
    chk("sw_mem_addr", bus.mem_addr, 32'h4);
    chk("sw_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    drain();

`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 32'h6, 0, 5'd8, 1, 32'd0, 0, 1, 1);
    @(negedge clk);
    chk("lw_trap_no_read", 32'(bus.mem_read), 32'd0);
    drain();
    issue(0, 2'b01, 0, 32'h9, 0, 5'd11, 1, 32'd0, 0, 1, 1); drain();
    issue(1, 2'b01, 0, 32'h5, 32'h0000_7777, 5'd12, 1, 32'd0, 0, 1, 1); drain();
    issue(0, 2'b10, 0, 32'h4, 0, 5'd13, 1, 32'hDEAD_BEEF, 1, 0, 2); drain();
`else
    issue(0, 2'b10, 0, 32'h6, 0, 5'd8, 1, 32'hDEAD_BEEF, 1, 0, 2); drain();
    issue(0, 2'b01, 0, 32'h9, 0, 5'd11, 1, 32'h0000_11AB, 1, 0, 2); drain();
    issue(1, 2'b01, 0, 32'h5, 32'h0000_7777, 5'd12, 1, 32'd0, 0, 0, 3); drain();
    issue(0, 2'b10, 0, 32'h4, 0, 5'd13, 1, 32'h7777_BEEF, 1, 0, 2); drain();
`endif

    // SH at offset 2, then reserved size
    issue(1, 2'b01, 0, 32'hE, 32'h0000_1234, 5'd14, 1, 32'd0, 0, 0, 3); drain();
    issue(0, 2'b10, 0, 32'hC, 0, 5'd15, 1, 32'hCAFE_1234, 1, 0, 2); drain();
    issue(0, 2'b11, 0, 32'h8, 0, 5'd9, 1, 32'd0, 0, 0, 1); drain();

    // Request held while busy must be ignored
    issue(0, 2'b10, 0, 32'h8, 0, 5'd16, 1, 32'h11AB_80FF, 1, 0, 2);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h8;
    bus.req_wdata = 32'd0;
    bus.req_rd    = 5'd17;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drain();

    // Reset landing on the WR cycle of an SH suppresses the write
    issue(1, 2'b01, 0, 32'hC, 32'h0000_5555, 5'd10, 0, 32'd0, 0, 0, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_in_wr_mem_write", 32'(bus.mem_write), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("post_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    chk("mem_word_4", mem[1],
`ifdef LSU_MISALIGN_TRAP_EN
        32'hDEAD_BEEF);
`else
        32'h7777_BEEF);
`endif
    chk("mem_word_8", mem[2], 32'h11AB_80FF);
    chk("mem_word_c", mem[3], 32'hCAFE_1234);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
